// File: rtl/ps_update_ctrl_if.sv
// rtl/ps_update_ctrl_if.sv - update-request, pipeline-drain, TLB-flush and committed-state signals of ps_update_ctrl
interface ps_update_ctrl_if;
   logic        i_upd_valid;
   logic        o_upd_ready;
   logic [1:0]  i_upd_priv;
   logic        i_upd_isa_c;
   logic [31:0] i_upd_satp;
   logic        i_pipe_empty;
   logic        o_stall_fetch;
   logic        o_tlb_flush_req;
   logic        i_tlb_flush_ack;
   logic [1:0]  o_priv;
   logic        o_isa_c;
   logic [31:0] o_satp;
   logic        o_upd_done;

   modport master (
      output i_upd_valid, i_upd_priv, i_upd_isa_c, i_upd_satp, i_pipe_empty, i_tlb_flush_ack,
      input  o_upd_ready, o_stall_fetch, o_tlb_flush_req, o_priv, o_isa_c, o_satp, o_upd_done
   );

   modport slave (
      input  i_upd_valid, i_upd_priv, i_upd_isa_c, i_upd_satp, i_pipe_empty, i_tlb_flush_ack,
      output o_upd_ready, o_stall_fetch, o_tlb_flush_req, o_priv, o_isa_c, o_satp, o_upd_done
   );
endinterface

// File: rtl/ps_update_ctrl.sv
// rtl/ps_update_ctrl.sv - sequences atomic priv/isa_c/satp updates: stall, drain, optional TLB flush, commit
// Optional commit logging when PS_UPDATE_LOG_EN is defined (simulation only).
module ps_update_ctrl #(
   parameter logic [1:0] PRIV_RESET        = 2'b11,
   parameter logic       ISA_C_RESET       = 1'b1,
   parameter bit         TLB_FLUSH_ON_PRIV = 1'b0
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   ps_update_ctrl_if.slave bus,
   input  logic [31:0]   i_log_fd
);

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_TLBF, S_COMMIT} state_t;

   state_t      state_q, state_d;
   logic [1:0]  pend_priv_q, pend_priv_d;
   logic        pend_isa_c_q, pend_isa_c_d;
   logic [31:0] pend_satp_q, pend_satp_d;
   logic [1:0]  priv_q, priv_d;
   logic        isa_c_q, isa_c_d;
   logic [31:0] satp_q, satp_d;
   logic        done_q, done_d;
   logic        flush_req_q, flush_req_d;
   logic        flush_needed;

   // Compared against committed values, so a request accepted on the done cycle sees the fresh state.
   assign flush_needed = (pend_satp_q != satp_q) |
                         (TLB_FLUSH_ON_PRIV & (pend_priv_q != priv_q));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= S_IDLE;
         pend_priv_q  <= 2'b00;
         pend_isa_c_q <= 1'b0;
         pend_satp_q  <= 32'h0;
         priv_q       <= PRIV_RESET;
         isa_c_q      <= ISA_C_RESET;
         satp_q       <= 32'h0;
         done_q       <= 1'b0;
         flush_req_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         pend_priv_q  <= pend_priv_d;
         pend_isa_c_q <= pend_isa_c_d;
         pend_satp_q  <= pend_satp_d;
         priv_q       <= priv_d;
         isa_c_q      <= isa_c_d;
         satp_q       <= satp_d;
         done_q       <= done_d;
         flush_req_q  <= flush_req_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pend_priv_d  = pend_priv_q;
      pend_isa_c_d = pend_isa_c_q;
      pend_satp_d  = pend_satp_q;
      priv_d       = priv_q;
      isa_c_d      = isa_c_q;
      satp_d       = satp_q;
      done_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.i_upd_valid) begin
               pend_priv_d  = bus.i_upd_priv;
               pend_isa_c_d = bus.i_upd_isa_c;
               pend_satp_d  = bus.i_upd_satp;
               state_d      = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (bus.i_pipe_empty) state_d = flush_needed ? S_TLBF : S_COMMIT;
         end
         S_TLBF: begin
            if (bus.i_tlb_flush_ack) state_d = S_COMMIT;
         end
         S_COMMIT: begin
            priv_d  = pend_priv_q;
            isa_c_d = pend_isa_c_q;
            satp_d  = pend_satp_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Registered level request: high exactly while the next state is TLBF.
      flush_req_d = (state_d == S_TLBF);
   end

   assign bus.o_upd_ready     = (state_q == S_IDLE);
   assign bus.o_stall_fetch   = (state_q != S_IDLE);
   assign bus.o_tlb_flush_req = flush_req_q;
   assign bus.o_priv          = priv_q;
   assign bus.o_isa_c         = isa_c_q;
   assign bus.o_satp          = satp_q;
   assign bus.o_upd_done      = done_q;

`ifdef PS_UPDATE_LOG_EN
   logic flushed_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                flushed_q <= 1'b0;
      else if (state_q == S_TLBF)  flushed_q <= 1'b1;
      else if (state_q == S_IDLE)  flushed_q <= 1'b0;
   end

   always @(posedge i_clk) begin
      if (i_rst_n && state_q == S_COMMIT)
         $display("ps_update[%0d]: priv %0d->%0d isa_c %0d->%0d satp %08h->%08h tlb_flush=%0d",
                  i_log_fd, priv_q, pend_priv_q, isa_c_q, pend_isa_c_q, satp_q, pend_satp_q, flushed_q);
   end
`else
   logic unused_log_fd;
   assign unused_log_fd = |i_log_fd;
`endif

endmodule

// File: tb/tb_ps_update_ctrl.sv
// tb/tb_ps_update_ctrl.sv - directed self-checking bench for ps_update_ctrl
module tb_ps_update_ctrl;
   logic        clk;
   logic        rst_n;
   logic [31:0] log_fd;
   int          total;
   int          bad;
   int          req_cycles;

   ps_update_ctrl_if u_if();

   ps_update_ctrl u_dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .bus      (u_if),
      .i_log_fd (log_fd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic [1:0] p, input logic c, input logic [31:0] s);
      u_if.i_upd_valid = 1'b1;
      u_if.i_upd_priv  = p;
      u_if.i_upd_isa_c = c;
      u_if.i_upd_satp  = s;
   endtask

   task automatic chk_state(input string tag, input logic [1:0] p, input logic c, input logic [31:0] s);
      chk({tag, ".priv"},  {30'd0, u_if.o_priv},  {30'd0, p});
      chk({tag, ".isa_c"}, {31'd0, u_if.o_isa_c}, {31'd0, c});
      chk({tag, ".satp"},  u_if.o_satp, s);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      log_fd = 32'h0;
      rst_n = 1'b0;
      u_if.i_upd_valid     = 1'b0;
      u_if.i_upd_priv      = 2'b00;
      u_if.i_upd_isa_c     = 1'b0;
      u_if.i_upd_satp      = 32'h0;
      u_if.i_pipe_empty    = 1'b1;
      u_if.i_tlb_flush_ack = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // reset values
      chk_state("rst", 2'b11, 1'b1, 32'h0);
      chk("rst.req",   {31'd0, u_if.o_tlb_flush_req}, 32'd0);
      chk("rst.done",  {31'd0, u_if.o_upd_done}, 32'd0);
      chk("rst.ready", {31'd0, u_if.o_upd_ready}, 32'd1);
      chk("rst.stall", {31'd0, u_if.o_stall_fetch}, 32'd0);

      // stray ack in IDLE
      u_if.i_tlb_flush_ack = 1'b1;
      tick();
      u_if.i_tlb_flush_ack = 1'b0;
      chk("ack_idle.ready", {31'd0, u_if.o_upd_ready}, 32'd1);
      chk("ack_idle.req",   {31'd0, u_if.o_tlb_flush_req}, 32'd0);
      chk_state("ack_idle", 2'b11, 1'b1, 32'h0);

      // priv-only change M->S, pipe empty: commit at T+3, no flush
      drive_req(2'b01, 1'b1, 32'h0);
      tick();
      u_if.i_upd_valid = 1'b0;
      chk("p2s.T1.ready", {31'd0, u_if.o_upd_ready}, 32'd0);
      chk("p2s.T1.stall", {31'd0, u_if.o_stall_fetch}, 32'd1);
      tick();
      chk("p2s.T2.req",  {31'd0, u_if.o_tlb_flush_req}, 32'd0);
      chk("p2s.T2.priv", {30'd0, u_if.o_priv}, 32'd3);
      chk("p2s.T2.done", {31'd0, u_if.o_upd_done}, 32'd0);
      tick();
      chk_state("p2s.T3", 2'b01, 1'b1, 32'h0);
      chk("p2s.T3.done",  {31'd0, u_if.o_upd_done}, 32'd1);
      chk("p2s.T3.ready", {31'd0, u_if.o_upd_ready}, 32'd1);
      chk("p2s.T3.stall", {31'd0, u_if.o_stall_fetch}, 32'd0);
      tick();
      chk("p2s.T4.done", {31'd0, u_if.o_upd_done}, 32'd0);

      // satp change, pipe busy for 5 DRAIN cycles, ack two cycles after req
      drive_req(2'b01, 1'b1, 32'h8000_0123);
      u_if.i_pipe_empty = 1'b0;
      tick();
      u_if.i_upd_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("satp.drain.stall", {31'd0, u_if.o_stall_fetch}, 32'd1);
         chk("satp.drain.req",   {31'd0, u_if.o_tlb_flush_req}, 32'd0);
         u_if.i_tlb_flush_ack = (i == 2);
         tick();
      end
      u_if.i_tlb_flush_ack = 1'b0;
      chk("satp.drain_end.req", {31'd0, u_if.o_tlb_flush_req}, 32'd0);
      u_if.i_pipe_empty = 1'b1;
      tick();
      req_cycles = 0;
      for (int i = 0; i < 3; i++) begin
         if (u_if.o_tlb_flush_req) req_cycles++;
         chk("satp.tlbf.stall", {31'd0, u_if.o_stall_fetch}, 32'd1);
         chk("satp.tlbf.satp",  u_if.o_satp, 32'h0);
         u_if.i_tlb_flush_ack = (i == 2);
         tick();
      end
      u_if.i_tlb_flush_ack = 1'b0;
      chk("satp.req_cycles", req_cycles, 32'd3);
      chk("satp.commit.req",   {31'd0, u_if.o_tlb_flush_req}, 32'd0);
      chk("satp.commit.stall", {31'd0, u_if.o_stall_fetch}, 32'd1);
      chk("satp.commit.satp",  u_if.o_satp, 32'h0);
      u_if.i_pipe_empty = 1'b0;
      tick();
      u_if.i_pipe_empty = 1'b1;
      chk_state("satp.done", 2'b01, 1'b1, 32'h8000_0123);
      chk("satp.done.done",  {31'd0, u_if.o_upd_done}, 32'd1);
      chk("satp.done.stall", {31'd0, u_if.o_stall_fetch}, 32'd0);

      // second request during DRAIN must wait and then compare against new satp
      drive_req(2'b00, 1'b0, 32'h8000_0123);
      tick();
      drive_req(2'b01, 1'b1, 32'h0000_DEAD);
      tick();
      chk("hold.commit.req", {31'd0, u_if.o_tlb_flush_req}, 32'd0);
      tick();
      chk_state("hold.first", 2'b00, 1'b0, 32'h8000_0123);
      chk("hold.first.done", {31'd0, u_if.o_upd_done}, 32'd1);
      tick();
      u_if.i_upd_valid = 1'b0;
      chk("hold.drain.ready", {31'd0, u_if.o_upd_ready}, 32'd0);
      tick();
      chk("hold.tlbf.req", {31'd0, u_if.o_tlb_flush_req}, 32'd1);
      u_if.i_tlb_flush_ack = 1'b1;
      tick();
      u_if.i_tlb_flush_ack = 1'b0;
      chk("hold.commit2.req", {31'd0, u_if.o_tlb_flush_req}, 32'd0);
      tick();
      chk_state("hold.second", 2'b01, 1'b1, 32'h0000_DEAD);
      chk("hold.second.done", {31'd0, u_if.o_upd_done}, 32'd1);

      // back-to-back identical requests: done every 3 cycles, no flush
      drive_req(2'b01, 1'b1, 32'h0000_DEAD);
      for (int k = 1; k <= 9; k++) begin
         if (k == 9) u_if.i_upd_valid = 1'b0;
         tick();
         chk("b2b.done", {31'd0, u_if.o_upd_done}, (k % 3 == 0) ? 32'd1 : 32'd0);
         chk("b2b.req",  {31'd0, u_if.o_tlb_flush_req}, 32'd0);
         chk_state("b2b", 2'b01, 1'b1, 32'h0000_DEAD);
      end
      tick();
      chk("b2b.idle.ready", {31'd0, u_if.o_upd_ready}, 32'd1);
      chk("b2b.idle.done",  {31'd0, u_if.o_upd_done}, 32'd0);

      // async reset while in TLBF
      drive_req(2'b00, 1'b0, 32'h0000_1234);
      tick();
      u_if.i_upd_valid = 1'b0;
      tick();
      chk("rst_tlbf.req_before", {31'd0, u_if.o_tlb_flush_req}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk_state("rst_tlbf", 2'b11, 1'b1, 32'h0);
      chk("rst_tlbf.req",   {31'd0, u_if.o_tlb_flush_req}, 32'd0);
      chk("rst_tlbf.ready", {31'd0, u_if.o_upd_ready}, 32'd1);
      chk("rst_tlbf.stall", {31'd0, u_if.o_stall_fetch}, 32'd0);
      tick();
      rst_n = 1'b1;
      u_if.i_tlb_flush_ack = 1'b1;
      tick();
      u_if.i_tlb_flush_ack = 1'b0;
      tick();
      chk("post_rst.ready", {31'd0, u_if.o_upd_ready}, 32'd1);
      chk("post_rst.done",  {31'd0, u_if.o_upd_done}, 32'd0);
      chk_state("post_rst", 2'b11, 1'b1, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
